// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared widths, constants and loader state encoding
// for the instruction ROM/loader block.
//   InstBusW / InstAddrBusW : instruction word / fetch address widths
//   InstMemNumLog2          : log2 of the number of instruction words
//   ZeroWord                : all-zero instruction word
//   ld_state_e              : loader FSM state encoding
package inst_rom_loader_pkg;

   localparam int unsigned InstBusW       = 32;
   localparam int unsigned InstAddrBusW   = 32;
   localparam int unsigned InstMemNumLog2 = 10;
   localparam int unsigned ByteW          = 8;

   localparam logic [InstBusW-1:0] ZeroWord = InstBusW'(0);

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_DONE = 2'd2
   } ld_state_e;

   // Left-justify a partially assembled word: cnt is the number of bytes
   // already held before the final byte, so cnt+1 low bytes are valid.
   function automatic logic [InstBusW-1:0] zero_fill(input logic [InstBusW-1:0] w,
                                                     input logic [1:0]          cnt);
      logic [InstBusW-1:0] r;
      case (cnt)
         2'd0:    r = {w[7:0],  24'h00_0000};
         2'd1:    r = {w[15:0], 16'h0000};
         2'd2:    r = {w[23:0], 8'h00};
         default: r = w;
      endcase
      return r;
   endfunction

endpackage : inst_rom_loader_pkg

// File: rtl/inst_rom_loader_if.sv
// inst_rom_loader_if: fetch and byte-loader signals between the core/SoC
// side (master) and the instruction ROM loader (slave).
//   rom_ce/rom_addr -> rom_data       : instruction fetch, 1-cycle latency
//   ld_start/ld_valid/ld_byte/ld_last : byte-stream load, ld_ready accepts
//   ld_done/busy                      : session complete pulse / load active
//   addr_err                          : misaligned fetch flag (only when
//                                       INST_ROM_ALIGN_CHK_EN is defined)
interface inst_rom_loader_if;
   import inst_rom_loader_pkg::*;

   logic                    rom_ce;
   logic [InstAddrBusW-1:0] rom_addr;
   logic [InstBusW-1:0]     rom_data;
   logic                    ld_start;
   logic                    ld_valid;
   logic [ByteW-1:0]        ld_byte;
   logic                    ld_ready;
   logic                    ld_last;
   logic                    ld_done;
   logic                    busy;
`ifdef INST_ROM_ALIGN_CHK_EN
   logic                    addr_err;

   modport master (
      output rom_ce, rom_addr, ld_start, ld_valid, ld_byte, ld_last,
      input  rom_data, ld_ready, ld_done, busy, addr_err
   );

   modport slave (
      input  rom_ce, rom_addr, ld_start, ld_valid, ld_byte, ld_last,
      output rom_data, ld_ready, ld_done, busy, addr_err
   );
`else
   modport master (
      output rom_ce, rom_addr, ld_start, ld_valid, ld_byte, ld_last,
      input  rom_data, ld_ready, ld_done, busy
   );

   modport slave (
      input  rom_ce, rom_addr, ld_start, ld_valid, ld_byte, ld_last,
      output rom_data, ld_ready, ld_done, busy
   );
`endif

endinterface : inst_rom_loader_if

// File: rtl/inst_rom_mem.sv
// inst_rom_mem: instruction word array with one synchronous write port and
// one registered read port; the read register loads zero when re_i is low.
// Array contents have no reset.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i, rdata_o : registered read port
module inst_rom_mem #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem_q [Depth];
   logic [DATA_W-1:0] rdata_q;

   // Write port
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read, zero when not enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= DATA_W'(0);
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end else begin
         rdata_q <= DATA_W'(0);
      end
   end

   assign rdata_o = rdata_q;

endmodule : inst_rom_mem

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction memory for the core's fetch port plus a
// big-endian byte-stream loader that (re)writes the program at run time.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : inst_rom_loader_if.slave (fetch, loader handshake, status)
// Optional: define INST_ROM_ALIGN_CHK_EN to add bus.addr_err, which flags
// fetches with rom_addr[1:0] != 0 and forces their rom_data to zero.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = InstMemNumLog2,
   parameter int unsigned DATA_W     = InstBusW
) (
   input  logic             clk,
   input  logic             rst,
   inst_rom_loader_if.slave bus
);

   ld_state_e             state_q,  state_d;
   logic [1:0]            cnt_q,    cnt_d;
   logic [DEPTH_LOG2-1:0] ptr_q,    ptr_d;
   logic [InstBusW-1:0]   shift_q,  shift_d;
   logic                  busy_q;
   logic                  ld_ready_q;
   logic                  ld_done_q;

   logic                  accept_c;
   logic [InstBusW-1:0]   assembled_c;
   logic                  we_c;
   logic [DATA_W-1:0]     wdata_c;
   logic                  in_range_c;
   logic                  re_c;
   logic [DEPTH_LOG2-1:0] raddr_c;

   assign accept_c    = bus.ld_valid && ld_ready_q;
   assign assembled_c = {shift_q[InstBusW-ByteW-1:0], bus.ld_byte};

   // Next-state, byte assembly and memory write decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      shift_d = shift_q;
      we_c    = 1'b0;
      wdata_c = DATA_W'(assembled_c);
      case (state_q)
         LD_IDLE: begin
            if (bus.ld_start) begin
               state_d = LD_LOAD;
               cnt_d   = 2'd0;
               ptr_d   = DEPTH_LOG2'(0);
               shift_d = ZeroWord;
            end
         end
         LD_LOAD: begin
            if (accept_c) begin
               shift_d = assembled_c;
               cnt_d   = cnt_q + 2'd1;
               // Full word, or final partial word left-justified; pointer
               // wraps naturally at the top of the array.
               if ((cnt_q == 2'd3) || bus.ld_last) begin
                  we_c    = 1'b1;
                  wdata_c = DATA_W'(zero_fill(assembled_c, cnt_q));
                  ptr_d   = ptr_q + DEPTH_LOG2'(1);
               end
               if (bus.ld_last) begin
                  state_d = LD_DONE;
               end
            end
         end
         LD_DONE: begin
            state_d = LD_IDLE;
         end
         default: begin
            state_d = LD_IDLE;
         end
      endcase
   end

   // State and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= LD_IDLE;
         cnt_q      <= 2'd0;
         ptr_q      <= DEPTH_LOG2'(0);
         shift_q    <= ZeroWord;
         busy_q     <= 1'b0;
         ld_ready_q <= 1'b0;
         ld_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         shift_q    <= shift_d;
         busy_q     <= (state_d != LD_IDLE);
         ld_ready_q <= (state_d == LD_LOAD);
         ld_done_q  <= (state_d == LD_DONE);
      end
   end

   // Fetch decode: serviced only in IDLE and only for in-range addresses
   assign in_range_c = (bus.rom_addr[InstAddrBusW-1:DEPTH_LOG2+2] == '0);
   assign raddr_c    = bus.rom_addr[DEPTH_LOG2+1:2];

`ifdef INST_ROM_ALIGN_CHK_EN
   logic misaligned_c;
   logic addr_err_q;

   assign misaligned_c = (bus.rom_addr[1:0] != 2'b00);
   assign re_c = bus.rom_ce && (state_q == LD_IDLE) && in_range_c && !misaligned_c;

   // Misalignment flag, same latency as rom_data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= bus.rom_ce && misaligned_c;
      end
   end

   assign bus.addr_err = addr_err_q;
`else
   logic unused_addr_lsb_c;

   // Byte offset within the word is ignored; access truncates to the word
   assign unused_addr_lsb_c = ^bus.rom_addr[1:0];
   assign re_c = bus.rom_ce && (state_q == LD_IDLE) && in_range_c;
`endif

   inst_rom_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst),
      .we_i    (we_c),
      .waddr_i (ptr_q),
      .wdata_i (wdata_c),
      .re_i    (re_c),
      .raddr_i (raddr_c),
      .rdata_o (bus.rom_data)
   );

   assign bus.busy     = busy_q;
   assign bus.ld_ready = ld_ready_q;
   assign bus.ld_done  = ld_done_q;

endmodule : inst_rom_loader

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: directed self-checking bench for inst_rom_loader.
module tb_inst_rom_loader;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   inst_rom_loader_if bus ();

   inst_rom_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rom_ce   = 1'b0;
      bus.rom_addr = 32'h0;
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_byte  = 8'h00;
      bus.ld_last  = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] addr, output logic [31:0] data, output logic err);
      bus.rom_ce   = 1'b1;
      bus.rom_addr = addr;
      tick();
      data = bus.rom_data;
`ifdef INST_ROM_ALIGN_CHK_EN
      err = bus.addr_err;
`else
      err = 1'b0;
`endif
      bus.rom_ce   = 1'b0;
      bus.rom_addr = 32'h0;
   endtask

   // One load session; with gaps, two idle cycles precede each byte after the
   // first, during which a fetch of word 0 and a stray ld_start are driven.
   task automatic run_load(input logic [7:0] b [8], input int n, input bit gaps,
                           output int done_cnt, output logic busy_in, output logic ready_in,
                           output logic done_at_last, output logic ready_at_last,
                           output logic busy_at_last, output logic busy_after,
                           output logic [31:0] blank_or);
      done_cnt      = 0;
      blank_or      = 32'h0;
      done_at_last  = 1'b0;
      ready_at_last = 1'b0;
      busy_at_last  = 1'b0;
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      busy_in  = bus.busy;
      ready_in = bus.ld_ready;
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) begin
            for (int g = 0; g < 2; g++) begin
               bus.ld_valid = 1'b0;
               bus.rom_ce   = 1'b1;
               bus.rom_addr = 32'h0;
               bus.ld_start = (g == 0);
               tick();
               blank_or = blank_or | bus.rom_data;
               done_cnt = done_cnt + int'(bus.ld_done);
            end
            bus.rom_ce   = 1'b0;
            bus.ld_start = 1'b0;
         end
         bus.ld_valid = 1'b1;
         bus.ld_byte  = b[i];
         bus.ld_last  = (i == n - 1);
         tick();
         done_cnt = done_cnt + int'(bus.ld_done);
         if (i == n - 1) begin
            done_at_last  = bus.ld_done;
            ready_at_last = bus.ld_ready;
            busy_at_last  = bus.busy;
         end
      end
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      tick();
      busy_after = bus.busy;
      done_cnt = done_cnt + int'(bus.ld_done);
      for (int k = 0; k < 2; k++) begin
         tick();
         done_cnt = done_cnt + int'(bus.ld_done);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (bus.rom_data !== 32'h0) $display("FAIL reset_rom_data: got %h expected %h", bus.rom_data, 32'h0); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
      checks++; if (bus.ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready); else passed++;
      checks++; if (bus.ld_done !== 1'b0) $display("FAIL reset_ld_done: got %b expected 0", bus.ld_done); else passed++;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b0) $display("FAIL idle_status: got busy=%b ready=%b expected 0/0", bus.busy, bus.ld_ready); else passed++;
   endtask

   task automatic test_load_two_words();
      logic [7:0] v [8];
      int dc; logic bi, ri, dl, rl, bl, ba, e; logic [31:0] bo, d;
      v = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
      run_load(v, 8, 1'b0, dc, bi, ri, dl, rl, bl, ba, bo);
      checks++; if (bi !== 1'b1) $display("FAIL load_busy: got %b expected 1", bi); else passed++;
      checks++; if (ri !== 1'b1) $display("FAIL load_ready: got %b expected 1", ri); else passed++;
      checks++; if (dc !== 1) $display("FAIL load_done_count: got %0d expected 1", dc); else passed++;
      checks++; if (dl !== 1'b1) $display("FAIL done_timing: got %b expected 1", dl); else passed++;
      checks++; if (rl !== 1'b0) $display("FAIL done_ready: got %b expected 0", rl); else passed++;
      checks++; if (bl !== 1'b1) $display("FAIL done_busy: got %b expected 1", bl); else passed++;
      checks++; if (ba !== 1'b0) $display("FAIL busy_drop: got %b expected 0", ba); else passed++;
      fetch(32'h0, d, e);
      checks++; if (d !== 32'h3402_0001) $display("FAIL fetch_w0: got %h expected %h", d, 32'h3402_0001); else passed++;
      fetch(32'h4, d, e);
      checks++; if (d !== 32'h3403_0002) $display("FAIL fetch_w1: got %h expected %h", d, 32'h3403_0002); else passed++;
      fetch(32'h0, d, e);
      checks++; if (d !== 32'h3402_0001) $display("FAIL fetch_w0_again: got %h expected %h", d, 32'h3402_0001); else passed++;
   endtask

   task automatic test_partial_word();
      logic [7:0] v [8];
      int dc; logic bi, ri, dl, rl, bl, ba, e; logic [31:0] bo, d;
      v = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(v, 2, 1'b0, dc, bi, ri, dl, rl, bl, ba, bo);
      checks++; if (dc !== 1) $display("FAIL partial_done_count: got %0d expected 1", dc); else passed++;
      fetch(32'h0, d, e);
      checks++; if (d !== 32'hAABB_0000) $display("FAIL partial_w0: got %h expected %h", d, 32'hAABB_0000); else passed++;
      fetch(32'h4, d, e);
      checks++; if (d !== 32'h3403_0002) $display("FAIL partial_w1_kept: got %h expected %h", d, 32'h3403_0002); else passed++;
   endtask

   task automatic test_backpressure();
      logic [7:0] v [8];
      int dc; logic bi, ri, dl, rl, bl, ba, e; logic [31:0] bo, d;
      v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(v, 4, 1'b1, dc, bi, ri, dl, rl, bl, ba, bo);
      checks++; if (bo !== 32'h0) $display("FAIL load_blanking: got %h expected %h", bo, 32'h0); else passed++;
      checks++; if (dc !== 1) $display("FAIL gap_done_count: got %0d expected 1", dc); else passed++;
      fetch(32'h0, d, e);
      checks++; if (d !== 32'h1122_3344) $display("FAIL gap_w0: got %h expected %h", d, 32'h1122_3344); else passed++;
   endtask

   task automatic test_fetch_range();
      logic [31:0] d; logic e;
      fetch(32'h0000_1000, d, e);
      checks++; if (d !== 32'h0) $display("FAIL out_of_range: got %h expected %h", d, 32'h0); else passed++;
      fetch(32'h0, d, e);
      checks++; if (d !== 32'h1122_3344) $display("FAIL in_range_w0: got %h expected %h", d, 32'h1122_3344); else passed++;
      fetch(32'h8000_0000, d, e);
      checks++; if (d !== 32'h0) $display("FAIL out_of_range_hi: got %h expected %h", d, 32'h0); else passed++;
      fetch(32'h0, d, e);
      bus.rom_ce   = 1'b0;
      bus.rom_addr = 32'h0;
      tick();
      checks++; if (bus.rom_data !== 32'h0) $display("FAIL ce_low: got %h expected %h", bus.rom_data, 32'h0); else passed++;
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] v [8];
      logic [31:0] d; logic e;
      v = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'h00, 8'h00};
      // ld_start coincident with an IDLE fetch of word 1
      bus.rom_ce   = 1'b1;
      bus.rom_addr = 32'h4;
      bus.ld_start = 1'b1;
      tick();
      checks++; if (bus.rom_data !== 32'h3403_0002) $display("FAIL start_fetch: got %h expected %h", bus.rom_data, 32'h3403_0002); else passed++;
      checks++; if (bus.busy !== 1'b1) $display("FAIL start_busy: got %b expected 1", bus.busy); else passed++;
      bus.rom_ce   = 1'b0;
      bus.ld_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_byte  = v[i];
         tick();
      end
      bus.ld_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b0) $display("FAIL abort_status: got busy=%b ready=%b expected 0/0", bus.busy, bus.ld_ready); else passed++;
      tick();
      rst = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0) $display("FAIL abort_idle: got %b expected 0", bus.busy); else passed++;
      fetch(32'h0, d, e);
      checks++; if (d !== 32'h5566_7788) $display("FAIL abort_w0: got %h expected %h", d, 32'h5566_7788); else passed++;
      fetch(32'h4, d, e);
      checks++; if (d !== 32'h3403_0002) $display("FAIL abort_w1: got %h expected %h", d, 32'h3403_0002); else passed++;
   endtask

   task automatic test_align();
      logic [31:0] d; logic e;
      fetch(32'h2, d, e);
`ifdef INST_ROM_ALIGN_CHK_EN
      checks++; if (e !== 1'b1) $display("FAIL align_err: got %b expected 1", e); else passed++;
      checks++; if (d !== 32'h0) $display("FAIL align_data: got %h expected %h", d, 32'h0); else passed++;
      fetch(32'h0, d, e);
      checks++; if (e !== 1'b0) $display("FAIL align_ok_err: got %b expected 0", e); else passed++;
      checks++; if (d !== 32'h5566_7788) $display("FAIL align_ok_data: got %h expected %h", d, 32'h5566_7788); else passed++;
`else
      checks++; if (d !== 32'h5566_7788) $display("FAIL truncated_fetch: got %h expected %h", d, 32'h5566_7788); else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_load_two_words();
      test_partial_word();
      test_backpressure();
      test_fetch_range();
      test_reset_mid_load();
      test_align();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_inst_rom_loader

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder for the CPU core's fetch port: answers `rom_ce`/`rom_addr` requests with `rom_data`.
- Also contains a byte-stream loader that fills the memory with a program before or between runs, so the core's instruction source can be written at run time.
- Sits beside the core at the top-level SoC wrapper. The fetch side is the memory end of the core's instruction-fetch interface.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words held (1024 words).
- DATA_W, 32, instruction word width; fixed at 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce  input  1  fetch enable from the core.
- rom_addr  input  32  byte address from the core's PC.
- rom_data  output  32  fetched instruction word.
- ld_start  input  1  pulse; begins a load session at word 0.
- ld_valid  input  1  a load byte is present on `ld_byte`.
- ld_byte  input  8  load data byte, big-endian order within each word.
- ld_ready  output  1  loader accepts a byte this cycle.
- ld_last  input  1  qualifies the final byte of a load session.
- ld_done  output  1  one-cycle pulse when a session completes.
- busy  output  1  high while in LOAD; the core is held off by top-level logic.

Behaviour:
- Reset (`rst` low, async):
  - state=IDLE; byte counter=0; word pointer=0; shift register=0.
  - `rom_data`=0, `ld_ready`=0, `ld_done`=0, `busy`=0.
  - Memory contents are not cleared.
- Fetch path, state IDLE:
  - Word index = `rom_addr[DEPTH_LOG2+1:2]`. The `rom_data` register updates at the edge after the request (1-cycle latency).
  - `rom_ce`=0 → `rom_data` loads 0.
  - `rom_addr[31:DEPTH_LOG2+2]` nonzero (out of range) → `rom_data` loads 0.
- Fetch path, state LOAD: `rom_data` loads 0 regardless of `rom_ce`.
- State machine IDLE → LOAD:
  - Taken on `ld_start` while in IDLE.
  - Entry clears the byte counter, word pointer and shift register.
  - `busy`=1 from the next cycle.
  - `ld_start` while already in LOAD is ignored.
- LOAD handshake:
  - `ld_ready`=1 throughout LOAD; a byte is accepted when `ld_valid`&&`ld_ready`.
  - Each accepted byte: shift register = {shift[23:0], `ld_byte`}; byte counter +1 (mod 4).
  - On the 4th byte, the assembled word is written to mem[word pointer] in that same cycle, and the word pointer increments.
  - Word pointer reaching 2^DEPTH_LOG2: it wraps to 0 and overwriting continues; this is not an error.
- LOAD → DONE: on an accepted byte with `ld_last`=1.
  - If the byte counter is not at 3 (partial word), the remaining low bytes are zero-filled and that word is written.
- DONE: a single cycle.
  - `ld_done`=1, `ld_ready`=0, `busy`=1.
  - Next state IDLE; `busy` drops the cycle after.
- Simultaneous events:
  - `ld_start` in the same cycle as a fetch in IDLE: the fetch is serviced normally and LOAD begins next cycle.
  - A read and a write to the same word cannot collide, because fetches are blanked during LOAD.
- Reset during LOAD: the session aborts. Words already written stay written; the partial shift-register contents are discarded.

Optional Feature:
- Macro: INST_ROM_ALIGN_CHK_EN.
- When defined:
  - Adds output `addr_err` (1 bit, reset 0), registered with the same latency as `rom_data`.
  - `addr_err`=1 when `rom_ce`=1 and `rom_addr[1:0]`≠0; in that case `rom_data` is forced to 0.
- When undefined: no port is added, and `rom_addr[1:0]` is ignored (the access is truncated to the word).

Decomposition:
- Shared package/defines, added to the existing defines file:
  - `InstBus`/`InstAddrBus` widths.
  - ZeroWord.
  - Loader state encoding: LD_IDLE=2'd0, LD_LOAD=2'd1, LD_DONE=2'd2.
  - InstMemNumLog2.
- One sub-module: inst_rom_mem.
  - Single-port-write, single-port-read synchronous RAM holding the word array.
  - Has a registered read with zero output on read-enable low.
  - The FSM and byte assembler stay in the top block.

Test Plan:
- Reset then idle fetch: `rst` low 3 cycles, release, `rom_ce`=1, `rom_addr`=0 → `rom_data`=0 (unloaded memory) or the preloaded value, one cycle later. `busy`=0, `ld_ready`=0.
- Load 2 words: `ld_start`; bytes 34,02,00,01, 34,03,00,02 with `ld_last` on the 8th byte → `ld_done` pulses once. Then fetch addr 0x0 → 0x34020001 and fetch 0x4 → 0x34030002, each 1 cycle after the request.
- Partial word: load bytes AA,BB with `ld_last` on BB → mem[0]=0xAABB0000; fetch 0x0 returns 0xAABB0000.
- Backpressure gaps and blanking: `ld_valid` toggled 1,0,0,1,… across 4 bytes → only valid cycles count. During LOAD, `rom_ce`=1 at 0x0 → `rom_data`=0.
- Out-of-range and disabled fetch: fetch 0x00001000 (DEPTH_LOG2=10) → 0; `rom_ce`=0 → 0.
- Reset mid-load, then align check:
  - After 6 bytes, assert `rst` → state IDLE, `busy`=0; word 0 keeps its value, word 1 is unchanged.
  - With INST_ROM_ALIGN_CHK_EN defined, fetch 0x2 → `addr_err`=1, `rom_data`=0.
